// File: rtl/alarm_clock_if.sv
`default_nettype none
// ==========================================================================
// alarm_clock_if : button/alarm-control inputs and display/ring outputs
// Rev 1.0
// ==========================================================================
interface alarm_clock_if #(
   parameter int N_ALARM = 2
);
   localparam int c_IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;

   logic               up_p;
   logic               down_p;
   logic               center_p;
   logic [c_IDX_W-1:0] alarm_idx;
   logic [N_ALARM-1:0] alarm_en;
   logic [7:0]         hh_bcd;
   logic [7:0]         mm_bcd;
   logic [7:0]         ss_bcd;
   logic [2:0]         state_o;
   logic [N_ALARM-1:0] ring;
   logic               ring_any;
   logic               sec_tick;

   modport master (
      output up_p, down_p, center_p, alarm_idx, alarm_en,
      input  hh_bcd, mm_bcd, ss_bcd, state_o, ring, ring_any, sec_tick
   );

   modport slave (
      input  up_p, down_p, center_p, alarm_idx, alarm_en,
      output hh_bcd, mm_bcd, ss_bcd, state_o, ring, ring_any, sec_tick
   );
endinterface
`default_nettype wire

// File: rtl/alarm_clock_core.sv
`default_nettype none
// ==========================================================================
// alarm_clock_core : 24h clock with set FSM and N independent alarm channels
// Rev 1.0
// ==========================================================================
module alarm_clock_core #(
   parameter int CLK_DIV = 50000000,
   parameter int N_ALARM = 2,
   parameter int RING_S  = 60
) (
   input  wire          clk,
   input  wire          rst_n,
   alarm_clock_if.slave bus
);
   localparam int c_IDX_W = (N_ALARM > 1) ? $clog2(N_ALARM) : 1;
   localparam int c_DIV_W = $clog2(CLK_DIV);
   localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(CLK_DIV - 1);
   localparam logic [7:0]         c_RING_LAST = 8'(RING_S - 1);

   typedef enum logic [2:0] {
      S_RUN    = 3'd0,
      S_T_HOUR = 3'd1,
      S_T_MIN  = 3'd2,
      S_A_HOUR = 3'd3,
      S_A_MIN  = 3'd4
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [c_DIV_W-1:0] r_div;
   logic               r_sec_tick;
   logic [4:0]         r_hh;
   logic [5:0]         r_mm;
   logic [5:0]         r_ss;
   logic [4:0]         r_al_hh [N_ALARM];
   logic [5:0]         r_al_mm [N_ALARM];
   logic [7:0]         r_hh_bcd;
   logic [7:0]         r_mm_bcd;
   logic [7:0]         r_ss_bcd;
   logic [N_ALARM-1:0] w_ring;

   logic               w_up;
   logic               w_dn;
   logic               w_adj;
   logic               w_edit;
   logic               w_edit_nxt;
   logic               w_alarm_mode;
   logic               w_idx_ok;
   logic               w_tick;
   logic               w_clr_all;
   logic               w_ring_any;
   logic [c_IDX_W-1:0] w_sel;
   logic [4:0]         w_hh_step;
   logic [5:0]         w_mm_step;
   logic [4:0]         w_al_hh_step;
   logic [5:0]         w_al_mm_step;
   logic [5:0]         w_disp_h;
   logic [5:0]         w_disp_m;
   logic [5:0]         w_disp_s;

   function automatic logic [4:0] f_step_h(input logic [4:0] v, input logic up);
      logic [4:0] res;
      if (up) res = (v == 5'd23) ? 5'd0  : v + 5'd1;
      else    res = (v == 5'd0)  ? 5'd23 : v - 5'd1;
      return res;
   endfunction

   function automatic logic [5:0] f_step_m(input logic [5:0] v, input logic up);
      logic [5:0] res;
      if (up) res = (v == 6'd59) ? 6'd0  : v + 6'd1;
      else    res = (v == 6'd0)  ? 6'd59 : v - 6'd1;
      return res;
   endfunction

   function automatic logic [7:0] f_bcd(input logic [5:0] v);
      logic [5:0] rem;
      logic [3:0] tens;
      rem  = v;
      tens = 4'd0;
      for (int k = 0; k < 5; k++) begin
         if (rem >= 6'd10) begin
            rem  = rem - 6'd10;
            tens = tens + 4'd1;
         end
      end
      return {tens, 4'd0} | {2'b00, rem};
   endfunction

   // Simultaneous up/down cancels out
   assign w_up         = bus.up_p & ~bus.down_p;
   assign w_dn         = bus.down_p & ~bus.up_p;
   assign w_adj        = w_up | w_dn;
   assign w_edit       = (r_state == S_T_HOUR) || (r_state == S_T_MIN);
   assign w_edit_nxt   = (w_state_nxt == S_T_HOUR) || (w_state_nxt == S_T_MIN);
   assign w_alarm_mode = (r_state == S_A_HOUR) || (r_state == S_A_MIN);
   assign w_idx_ok     = int'(bus.alarm_idx) < N_ALARM;
   assign w_sel        = w_idx_ok ? bus.alarm_idx : '0;
   assign w_tick       = !w_edit && (r_div == c_DIV_LAST);
   assign w_ring_any   = |w_ring;
   assign w_clr_all    = ((r_state == S_RUN) && bus.center_p) || w_edit_nxt;

   assign w_hh_step    = f_step_h(r_hh, w_up);
   assign w_mm_step    = f_step_m(r_mm, w_up);
   assign w_al_hh_step = f_step_h(r_al_hh[w_sel], w_up);
   assign w_al_mm_step = f_step_m(r_al_mm[w_sel], w_up);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_RUN;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_RUN:    if (bus.center_p && !w_ring_any) w_state_nxt = S_T_HOUR;
         S_T_HOUR: if (bus.center_p) w_state_nxt = S_T_MIN;
         S_T_MIN:  if (bus.center_p) w_state_nxt = S_A_HOUR;
         S_A_HOUR: if (bus.center_p) w_state_nxt = S_A_MIN;
         S_A_MIN:  if (bus.center_p) w_state_nxt = S_RUN;
         default:  w_state_nxt = S_RUN;
      endcase
   end

   // The tick pulse is dropped when the FSM is about to freeze time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div      <= '0;
         r_sec_tick <= 1'b0;
      end else begin
         r_sec_tick <= w_tick && !w_edit_nxt;
         if (w_edit || w_tick) r_div <= '0;
         else                  r_div <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hh <= 5'd0;
         r_mm <= 6'd0;
         r_ss <= 6'd0;
      end else if (w_tick) begin
         if (r_ss == 6'd59) begin
            r_ss <= 6'd0;
            if (r_mm == 6'd59) begin
               r_mm <= 6'd0;
               r_hh <= (r_hh == 5'd23) ? 5'd0 : r_hh + 5'd1;
            end else begin
               r_mm <= r_mm + 6'd1;
            end
         end else begin
            r_ss <= r_ss + 6'd1;
         end
      end else if ((r_state == S_T_HOUR) && w_adj) begin
         r_hh <= w_hh_step;
      end else if ((r_state == S_T_MIN) && w_adj) begin
         r_mm <= w_mm_step;
         r_ss <= 6'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_ALARM; i++) begin
            r_al_hh[i] <= 5'd0;
            r_al_mm[i] <= 6'd0;
         end
      end else if (w_alarm_mode && w_idx_ok && w_adj) begin
         if (r_state == S_A_HOUR) r_al_hh[w_sel] <= w_al_hh_step;
         else                     r_al_mm[w_sel] <= w_al_mm_step;
      end
   end

   // Match is evaluated while the tick pulse is high, i.e. on the freshly advanced time
   generate
      for (genvar gi = 0; gi < N_ALARM; gi++) begin : g_ring
         logic [7:0] r_cnt;
         logic       r_bit;
         logic       w_match;
         logic       w_clr;

         assign w_match = r_sec_tick && bus.alarm_en[gi] && (r_ss == 6'd0)
                          && (r_hh == r_al_hh[gi]) && (r_mm == r_al_mm[gi]);
         assign w_clr   = w_clr_all || !bus.alarm_en[gi]
                          || (r_bit && r_sec_tick && (r_cnt == c_RING_LAST));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_bit <= 1'b0;
               r_cnt <= 8'd0;
            end else if (w_clr) begin
               r_bit <= 1'b0;
               r_cnt <= 8'd0;
            end else if (w_match) begin
               r_bit <= 1'b1;
               r_cnt <= 8'd0;
            end else if (r_bit && r_sec_tick) begin
               r_cnt <= r_cnt + 8'd1;
            end
         end

         assign w_ring[gi] = r_bit;
      end
   endgenerate

   always_comb begin
      w_disp_h = {1'b0, r_hh};
      w_disp_m = r_mm;
      w_disp_s = r_ss;
      if (w_alarm_mode) begin
         w_disp_s = 6'd0;
         if (w_idx_ok) begin
            w_disp_h = {1'b0, r_al_hh[w_sel]};
            w_disp_m = r_al_mm[w_sel];
         end else begin
            w_disp_h = 6'd0;
            w_disp_m = 6'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hh_bcd <= 8'h00;
         r_mm_bcd <= 8'h00;
         r_ss_bcd <= 8'h00;
      end else begin
         r_hh_bcd <= f_bcd(w_disp_h);
         r_mm_bcd <= f_bcd(w_disp_m);
         r_ss_bcd <= f_bcd(w_disp_s);
      end
   end

   assign bus.hh_bcd   = r_hh_bcd;
   assign bus.mm_bcd   = r_mm_bcd;
   assign bus.ss_bcd   = r_ss_bcd;
   assign bus.state_o  = r_state;
   assign bus.ring     = w_ring;
   assign bus.ring_any = w_ring_any;
   assign bus.sec_tick = r_sec_tick;
endmodule
`default_nettype wire
